// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : FIFO-buffered UART transmitter with optional parity, 1/2 stop
//               bits and a per-frame latched baud prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_MODE  = 0,
    parameter int OVERSAMPLING = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk_in,
    input  logic                          n_rst,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic [15:0]                   baud_div,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [LW-1:0]        level_q, level_d;
    logic                 full_q, empty_q, ovf_q;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [15:0]          div_q, div_d;
    logic [15:0]          presc_q, presc_d;
    logic [OW-1:0]        os_q, os_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 tick, bit_end;

    // full is the registered flag, so a write while full is refused even if a pop happens this cycle
    assign push    = wr_en && !full_q;
    assign level_d = level_q + LW'(push) - LW'(pop);
    assign head    = mem_q[rptr_q];

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == LW'(FIFO_DEPTH));
            empty_q <= (level_d == '0);
            ovf_q   <= wr_en && full_q;
        end
    end

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            div_q   <= '0;
            presc_q <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            div_q   <= div_d;
            presc_q <= presc_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        div_d   = div_q;
        presc_d = presc_q;
        os_d    = os_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        tick    = 1'b0;
        bit_end = 1'b0;

        if (state_q != S_IDLE) begin
            tick    = (presc_q == div_q);
            bit_end = tick && (os_q == OW'(OVERSAMPLING - 1));
            presc_d = tick ? '0 : presc_q + 16'd1;
            if (tick) begin
                os_d = bit_end ? '0 : os_q + OW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                pop = !empty_q;
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        pop     = !empty_q;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame start shared by the idle launch and the back-to-back stop->start hop
        if (pop) begin
            state_d = S_START;
            shift_d = head;
            par_d   = ^head;
            div_d   = baud_div;
            presc_d = '0;
            os_d    = '0;
            bit_d   = '0;
        end
    end

    always_comb begin
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = (PARITY_MODE == 2) ? ~par_q : par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Four transmitter variants (plain, even, odd, two stop bits)
//               share one stimulus stream and are checked against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        wr_en    = 1'b0;
    logic [7:0]  data_in  = 8'h00;
    logic [15:0] baud_div = 16'd0;

    logic [3:0] tx_v, busy_v, full_v, empty_v, ovf_v;
    logic [3:0] lvl_v [4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    uart_tx_fifo u_a (
        .clk_in(clk), .n_rst(rst_n), .wr_en(wr_en), .data_in(data_in), .baud_div(baud_div),
        .tx(tx_v[0]), .busy(busy_v[0]), .full(full_v[0]), .empty(empty_v[0]),
        .level(lvl_v[0]), .overflow(ovf_v[0]));

    uart_tx_fifo #(.PARITY_MODE(1)) u_e (
        .clk_in(clk), .n_rst(rst_n), .wr_en(wr_en), .data_in(data_in), .baud_div(baud_div),
        .tx(tx_v[1]), .busy(busy_v[1]), .full(full_v[1]), .empty(empty_v[1]),
        .level(lvl_v[1]), .overflow(ovf_v[1]));

    uart_tx_fifo #(.PARITY_MODE(2)) u_o (
        .clk_in(clk), .n_rst(rst_n), .wr_en(wr_en), .data_in(data_in), .baud_div(baud_div),
        .tx(tx_v[2]), .busy(busy_v[2]), .full(full_v[2]), .empty(empty_v[2]),
        .level(lvl_v[2]), .overflow(ovf_v[2]));

    uart_tx_fifo #(.STOP_BITS(2)) u_s (
        .clk_in(clk), .n_rst(rst_n), .wr_en(wr_en), .data_in(data_in), .baud_div(baud_div),
        .tx(tx_v[3]), .busy(busy_v[3]), .full(full_v[3]), .empty(empty_v[3]),
        .level(lvl_v[3]), .overflow(ovf_v[3]));

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d t=%0t actual=%0h required=%0h",
                     name, inst, cyc, $time, act, exp);
        end
    endtask

    // Reference model: each variant owns a word queue and the bit picture of
    // the frame in flight; tx is read off that picture by elapsed time.
    int          pm [4] = '{0, 1, 2, 0};
    int          sb [4] = '{1, 1, 1, 2};
    logic [7:0]  mq [4][8];
    int          mh [4] = '{0, 0, 0, 0};
    int          mc [4] = '{0, 0, 0, 0};
    logic [11:0] fb [4];
    int          nb [4] = '{0, 0, 0, 0};
    int          per [4] = '{16, 16, 16, 16};
    int          tt [4] = '{0, 0, 0, 0};
    bit          act [4] = '{0, 0, 0, 0};
    logic        exp_tx [4]   = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic        exp_busy [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic        exp_ovf [4]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          exp_lvl [4]  = '{0, 0, 0, 0};

    initial begin
        bit         was_full, do_pop;
        logic [7:0] w;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 4; i++) begin
                if (!rst_n) begin
                    act[i] = 0; mh[i] = 0; mc[i] = 0; tt[i] = 0;
                    exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_ovf[i] = 1'b0; exp_lvl[i] = 0;
                end else begin
                    was_full = (mc[i] == 8);
                    do_pop   = 0;
                    if (act[i]) begin
                        if (tt[i] == nb[i] * per[i] - 1) begin
                            act[i] = 0;
                            do_pop = (mc[i] > 0);
                        end else begin
                            tt[i]++;
                        end
                    end else begin
                        do_pop = (mc[i] > 0);
                    end
                    if (do_pop) begin
                        w = mq[i][mh[i]];
                        mh[i] = (mh[i] + 1) % 8;
                        mc[i]--;
                        fb[i] = '1;
                        fb[i][0] = 1'b0;
                        for (int k = 0; k < 8; k++) fb[i][1 + k] = w[k];
                        if (pm[i] != 0) fb[i][9] = (pm[i] == 1) ? ^w : ~^w;
                        nb[i]  = 1 + 8 + ((pm[i] != 0) ? 1 : 0) + sb[i];
                        per[i] = 16 * (int'(baud_div) + 1);
                        tt[i]  = 0;
                        act[i] = 1;
                    end
                    if (wr_en && !was_full) begin
                        mq[i][(mh[i] + mc[i]) % 8] = data_in;
                        mc[i]++;
                    end
                    exp_ovf[i]  = wr_en && was_full;
                    exp_busy[i] = act[i];
                    exp_tx[i]   = act[i] ? fb[i][tt[i] / per[i]] : 1'b1;
                    exp_lvl[i]  = mc[i];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                check("tx",       i, 32'(tx_v[i]),    32'(exp_tx[i]));
                check("busy",     i, 32'(busy_v[i]),  32'(exp_busy[i]));
                check("level",    i, 32'(lvl_v[i]),   exp_lvl[i]);
                check("full",     i, 32'(full_v[i]),  32'(exp_lvl[i] == 8));
                check("empty",    i, 32'(empty_v[i]), 32'(exp_lvl[i] == 0));
                check("overflow", i, 32'(ovf_v[i]),   32'(exp_ovf[i]));
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_v != 4'h0 || empty_v != 4'hF) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(name, 0, {24'h0, busy_v, empty_v}, 32'h0F);
        repeat (3) @(negedge clk);
        cyc = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx",    0, 32'(tx_v),    32'hF);
        check("rst_busy",  0, 32'(busy_v),  32'h0);
        check("rst_empty", 0, 32'(empty_v), 32'hF);
        check("rst_full",  0, 32'(full_v),  32'h0);
        check("rst_level", 0, 32'(lvl_v[0]), 32'h0);
        check("rst_ovf",   0, 32'(ovf_v),   32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cyc = 0;

        // 0x55, defaults
        wr_en = 1'b1; data_in = 8'h55;
        wait_to(1);  wr_en = 1'b0;
        check("t1_lvl1", 0, 32'(lvl_v[0]), 1);
        check("t1_empty1", 0, 32'(empty_v[0]), 0);
        wait_to(2);  check("t1_lvl2", 0, 32'(lvl_v[0]), 0);
                     check("t1_start", 0, 32'(tx_v[0]), 0);
                     check("t1_busy2", 0, 32'(busy_v[0]), 1);
        wait_to(17); check("t1_tx17", 0, 32'(tx_v[0]), 0);
        wait_to(18); check("t1_tx18", 0, 32'(tx_v[0]), 1);
        wait_to(34); check("t1_tx34", 0, 32'(tx_v[0]), 0);
        wait_to(145); check("t1_tx145", 0, 32'(tx_v[0]), 0);
        wait_to(146); check("t1_stop", 0, 32'(tx_v[0]), 1);
                      check("t1_par_e", 1, 32'(tx_v[1]), 0);
                      check("t1_par_o", 2, 32'(tx_v[2]), 1);
        wait_to(161); check("t1_busy161", 0, 32'(busy_v[0]), 1);
        wait_to(162); check("t1_busy162", 0, 32'(busy_v[0]), 0);
                      check("t1_empty162", 0, 32'(empty_v[0]), 1);
        wait_to(177); check("t1_e_busy177", 1, 32'(busy_v[1]), 1);
        wait_to(178); check("t1_e_busy178", 1, 32'(busy_v[1]), 0);
        wait_idle("t1_idle");

        // 0x07, parity variants
        wr_en = 1'b1; data_in = 8'h07;
        wait_to(1);  wr_en = 1'b0;
        wait_to(146); check("t2_par_e", 1, 32'(tx_v[1]), 1);
                      check("t2_par_o", 2, 32'(tx_v[2]), 0);
        wait_to(177); check("t2_s_busy177", 3, 32'(busy_v[3]), 1);
        wait_to(178); check("t2_e_busy178", 1, 32'(busy_v[1]), 0);
                      check("t2_s_busy178", 3, 32'(busy_v[3]), 0);
        wait_idle("t2_idle");

        // baud_div=2 with a mid-frame change that must wait for the next frame
        wr_en = 1'b1; data_in = 8'hA3; baud_div = 16'd2;
        wait_to(1);  wr_en = 1'b0;
        wait_to(49); check("t3_s_tx49", 3, 32'(tx_v[3]), 0);
        wait_to(50); check("t3_s_tx50", 3, 32'(tx_v[3]), 1);
        wait_to(100); baud_div = 16'd0; wr_en = 1'b1; data_in = 8'h3C;
        wait_to(101); wr_en = 1'b0;
        wait_to(289); check("t3_tx289", 0, 32'(tx_v[0]), 0);
        wait_to(290); check("t3_tx290", 0, 32'(tx_v[0]), 1);
        wait_to(481); check("t3_tx481", 0, 32'(tx_v[0]), 1);
        wait_to(482); check("t3_tx482", 0, 32'(tx_v[0]), 0);
                      check("t3_busy482", 0, 32'(busy_v[0]), 1);
        wait_to(497); check("t3_tx497", 0, 32'(tx_v[0]), 0);
        wait_to(529); check("t3_s_busy529", 3, 32'(busy_v[3]), 1);
        wait_to(530); check("t3_tx530", 0, 32'(tx_v[0]), 1);
                      check("t3_s_tx530", 3, 32'(tx_v[3]), 0);
        wait_idle("t3_idle");

        // words 1..10 into a depth-8 queue, then a write colliding with the stop->start pop
        for (int k = 1; k <= 10; k++) begin
            wr_en = 1'b1; data_in = 8'(k);
            wait_to(k);
            if (k == 2) check("t4_lvl2", 0, 32'(lvl_v[0]), 1);
        end
        wr_en = 1'b0;
        check("t4_ovf10", 0, 32'(ovf_v[0]), 1);
        check("t4_lvl10", 0, 32'(lvl_v[0]), 8);
        wait_to(11); check("t4_ovf11", 0, 32'(ovf_v[0]), 0);
        wait_to(161); wr_en = 1'b1; data_in = 8'hEE;
        check("t4_full161", 0, 32'(full_v[0]), 1);
        wait_to(162); wr_en = 1'b0;
        check("t4_ovf162", 0, 32'(ovf_v[0]), 1);
        check("t4_lvl162", 0, 32'(lvl_v[0]), 7);
        check("t4_tx162", 0, 32'(tx_v[0]), 0);
        check("t4_busy162", 0, 32'(busy_v[0]), 1);
        wait_idle("t4_idle");

        // asynchronous reset mid-DATA with three words still queued
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; data_in = 8'(8'h11 + k);
            wait_to(k + 1);
        end
        wr_en = 1'b0;
        wait_to(40);
        check("t5_lvl40", 0, 32'(lvl_v[0]), 3);
        #2 rst_n = 1'b0;
        #1;
        check("t5_tx",    0, 32'(tx_v),     32'hF);
        check("t5_busy",  0, 32'(busy_v),   32'h0);
        check("t5_level", 0, 32'(lvl_v[0]), 32'h0);
        check("t5_empty", 0, 32'(empty_v),  32'hF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("t5_idle_tx",   0, 32'(tx_v),   32'hF);
        check("t5_idle_busy", 0, 32'(busy_v), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter that succeeds the single-word transmitter. A synchronous write-side FIFO decouples producers from the serial line. The block adds optional even/odd parity, one or two stop bits, and a runtime baud prescaler. Queued words are sent back-to-back with no idle gap, which makes it the standard TX endpoint behind the buffer/FIFO datapath.

## Interface
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- STOP_BITS, 1: stop bits, 1 or 2.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- OVERSAMPLING, 16: prescaler ticks per bit, ≥2.
- FIFO_DEPTH, 8: FIFO entries, power of 2, ≥2.

- clk_in  in  1  system clock; all logic on rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request; accepted when full=0.
- data_in  in  DATA_BITS  word to enqueue.
- baud_div  in  16  bit period = OVERSAMPLING*(baud_div+1) clk_in cycles; latched at each frame start.
- tx  out  1  serial line, registered, idle high.
- busy  out  1  high while a frame is on the line.
- full  out  1  level == FIFO_DEPTH.
- empty  out  1  level == 0.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  one-cycle pulse when wr_en=1 while full=1 (word dropped).

## Operation
- Reset values: tx=1, busy=0, empty=1, full=0, level=0, overflow=0. FIFO pointers, shift register, counters cleared. FSM in IDLE.
- FIFO:
  - Write when wr_en && !full.
  - full is sampled before a same-cycle pop, so a write while full is rejected even if a pop occurs that cycle.
  - Simultaneous accepted write and pop leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE → START → DATA → PARITY → STOP.
  - IDLE: tx=1, busy=0. If !empty, pop the head word into the shift register, latch baud_div, clear counters, go to START.
  - START: tx=0 for one bit period, then go to DATA.
  - DATA: tx = shift_reg[0]. At the end of each bit period shift right and increment the bit counter. After DATA_BITS bits, go to PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: tx = XOR of the data word for even mode, its inverse for odd mode. Lasts one bit period, then go to STOP.
  - STOP: tx=1 for STOP_BITS bit periods.
    - On the last cycle, if !empty: pop, relatch baud_div, and go directly to START. The next start bit begins the following cycle.
    - Otherwise go to IDLE.
- Bit timing:
  - The prescaler counts 0..baud_div and produces one tick per wrap.
  - The bit counter advances on ticks; a bit ends after OVERSAMPLING ticks.
  - Counters are wide enough for baud_div=0xFFFF with no overflow.
- baud_div changes mid-frame have no effect until the next frame start.
- busy=1 from the first START cycle through the last STOP cycle. In back-to-back mode it stays continuously high.
- Asynchronous reset mid-frame: tx returns to 1 immediately, the FIFO is flushed, and the partial frame is abandoned.

## Timing
- Write into an empty FIFO in an idle block, wr_en high in cycle 0:
  - empty=0 and level=1 in cycle 1.
  - The FSM pops in cycle 1, so level=0 in cycle 2.
  - tx falls and busy rises in cycle 2.
- Frame length = (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) × OVERSAMPLING × (baud_div+1) cycles.
- overflow asserts in the cycle after the rejected write, for one cycle.
- level, full and empty are registered and update the cycle after the causing write/pop.

## Test plan
- Defaults, baud_div=0, write 0x55 at cycle 0:
  - tx=0 for cycles 2–17.
  - Then bits 1,0,1,0,1,0,1,0 at 16 cycles each.
  - Stop high for cycles 146–161.
  - busy falls at cycle 162, empty stays 1.
- PARITY_MODE=1, write 0x07: parity bit = 1. PARITY_MODE=2, write 0x07: parity bit = 0. Frame = 176 cycles.
- baud_div=2, STOP_BITS=2, write 0xA3:
  - Each bit lasts 48 cycles; frame = 528 cycles.
  - Change baud_div to 0 mid-frame: no change until the next frame.
- Write words 1..10 on cycles 0–9 from idle:
  - Word 1 is popped.
  - full=1 at cycle 9, level=8.
  - Word 10 is dropped; overflow pulses at cycle 10.
  - Words 1–9 go out back-to-back, each start bit immediately following the previous stop bit.
  - busy stays high throughout.
- At full, wr_en coincides with the STOP→START pop: the write is rejected, overflow pulses, level=7 next cycle.
- Assert n_rst=0 mid-DATA with 3 words queued:
  - tx=1, busy=0, level=0, empty=1 immediately.
  - After release, the line stays idle until a new write.
